// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: waits for a stable MMCM lock, then releases NSTAGE active-low resets
// one by one with a fixed gap. Tracks lock losses that occur after the first release.
module rst_seq_ctrl #(
  parameter int unsigned LOCK_STABLE_CYC = 1000,
  parameter int unsigned STAGE_GAP       = 100,
  parameter int unsigned NSTAGE          = 4
) (
  input  logic              sys_clk100m,
  input  logic              sys_rst,
  input  logic              locked_in,
  input  logic              sw_rst_req,
  output logic [NSTAGE-1:0] rst_n_stage,
  output logic              seq_done,
  output logic [1:0]        seq_state,
  output logic [7:0]        lock_lost_cnt
);

  typedef enum logic [1:0] {
    StWaitLock = 2'd0,
    StStable   = 2'd1,
    StRelease  = 2'd2,
    StRun      = 2'd3
  } state_e;

  localparam logic [15:0] StableLast = 16'(LOCK_STABLE_CYC - 1);
  localparam logic [15:0] GapLast    = 16'(STAGE_GAP - 1);

  logic              sync1_q, locked_sync_q;
  state_e            state_q, state_d;
  logic [15:0]       stab_cnt_q, stab_cnt_d;
  logic [15:0]       gap_cnt_q, gap_cnt_d;
  logic [NSTAGE-1:0] stage_q, stage_d;
  logic              done_q, done_d;
  logic [7:0]        lost_q, lost_d;
  logic [NSTAGE-1:0] stage_shift;

  // Next stage pattern: shift in one more released stage above the current ones.
  assign stage_shift = NSTAGE'({stage_q, 1'b1});

  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    stage_d    = stage_q;
    done_d     = done_q;
    lost_d     = lost_q;
    unique case (state_q)
      StWaitLock: begin
        stage_d = '0;
        done_d  = 1'b0;
        if (locked_sync_q) begin
          state_d    = StStable;
          stab_cnt_d = '0;
        end
      end
      StStable: begin
        if (!locked_sync_q) begin
          state_d    = StWaitLock;
          stab_cnt_d = '0;
        end else if (sw_rst_req) begin
          stab_cnt_d = '0;
        end else if (stab_cnt_q == StableLast) begin
          stab_cnt_d = '0;
          gap_cnt_d  = '0;
          stage_d    = '0;
          stage_d[0] = 1'b1;
          if (NSTAGE == 1) begin
            state_d = StRun;
            done_d  = 1'b1;
          end else begin
            state_d = StRelease;
          end
        end else begin
          stab_cnt_d = stab_cnt_q + 16'd1;
        end
      end
      StRelease, StRun: begin
        // Lock loss takes priority over a software request in the same cycle.
        if (!locked_sync_q) begin
          state_d = StWaitLock;
          stage_d = '0;
          done_d  = 1'b0;
          if (lost_q != 8'hff) lost_d = lost_q + 8'd1;
        end else if (sw_rst_req) begin
          state_d    = StStable;
          stab_cnt_d = '0;
          stage_d    = '0;
          done_d     = 1'b0;
        end else if (state_q == StRelease) begin
          if (gap_cnt_q == GapLast) begin
            gap_cnt_d = '0;
            stage_d   = stage_shift;
            if (&stage_shift) begin
              state_d = StRun;
              done_d  = 1'b1;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = StWaitLock;
    endcase
  end

  always_ff @(posedge sys_clk100m) begin
    if (sys_rst) begin
      sync1_q       <= 1'b0;
      locked_sync_q <= 1'b0;
      state_q       <= StWaitLock;
      stab_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      stage_q       <= '0;
      done_q        <= 1'b0;
      lost_q        <= '0;
    end else begin
      sync1_q       <= locked_in;
      locked_sync_q <= sync1_q;
      state_q       <= state_d;
      stab_cnt_q    <= stab_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      stage_q       <= stage_d;
      done_q        <= done_d;
      lost_q        <= lost_d;
    end
  end

  assign rst_n_stage   = stage_q;
  assign seq_done      = done_q;
  assign seq_state     = state_q;
  assign lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: directed sequence pins plus randomized lock/sw traffic checked
// every cycle against a model that tracks time elapsed since the last stable-lock start.
module tb_rst_seq_ctrl;

  localparam int unsigned L = 8;
  localparam int unsigned G = 4;
  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         sys_rst;
  logic         locked_in;
  logic         sw_rst_req;
  logic [N-1:0] rst_n_stage;
  logic         seq_done;
  logic [1:0]   seq_state;
  logic [7:0]   lock_lost_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state
  bit m_wait = 1'b1;
  int m_el   = 0;
  int m_lost = 0;
  bit m_s1   = 1'b0;
  bit m_s2   = 1'b0;

  rst_seq_ctrl #(
    .LOCK_STABLE_CYC(L),
    .STAGE_GAP      (G),
    .NSTAGE         (N)
  ) dut (
    .sys_clk100m  (clk),
    .sys_rst      (sys_rst),
    .locked_in    (locked_in),
    .sw_rst_req   (sw_rst_req),
    .rst_n_stage  (rst_n_stage),
    .seq_done     (seq_done),
    .seq_state    (seq_state),
    .lock_lost_cnt(lock_lost_cnt)
  );

  always #5 clk = ~clk;

  function automatic int released(input int e);
    int n;
    if (e < int'(L)) return 0;
    n = 1 + (e - int'(L)) / int'(G);
    return (n > int'(N)) ? int'(N) : n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic steps(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: elapsed cycles since entering stable-lock wait decide released stages.
  always @(posedge clk) begin
    if (sys_rst) begin
      m_wait = 1'b1; m_el = 0; m_lost = 0; m_s1 = 1'b0; m_s2 = 1'b0;
    end else begin
      if (m_wait) begin
        if (m_s2) begin
          m_wait = 1'b0;
          m_el   = 0;
        end
      end else if (!m_s2) begin
        if (released(m_el) > 0 && m_lost < 255) m_lost++;
        m_wait = 1'b1;
      end else if (sw_rst_req) begin
        m_el = 0;
      end else if (released(m_el) < int'(N)) begin
        m_el++;
      end
      m_s2 = m_s1;
      m_s1 = locked_in;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      logic [1:0] es;
      n  = m_wait ? 0 : released(m_el);
      es = m_wait ? 2'd0 : (n == 0) ? 2'd1 : (n < int'(N)) ? 2'd2 : 2'd3;
      chk("model rst_n_stage", 32'(rst_n_stage), 32'((1 << n) - 1));
      chk("model seq_done", 32'(seq_done), 32'(n == int'(N)));
      chk("model seq_state", 32'(seq_state), 32'(es));
      chk("model lock_lost_cnt", 32'(lock_lost_cnt), 32'(m_lost));
    end
  end

  initial begin
    sys_rst = 1'b1; locked_in = 1'b0; sw_rst_req = 1'b0;
    steps(3);
    chk("reset state", 32'(seq_state), 32'd0);
    chk("reset stages", 32'(rst_n_stage), 32'd0);
    chk("reset done", 32'(seq_done), 32'd0);
    chk("reset lost", 32'(lock_lost_cnt), 32'd0);
    chk_en = 1'b1;

    // Nominal release timeline, edge 0 is the first edge out of reset.
    sys_rst = 1'b0; locked_in = 1'b1;
    steps(3);  chk("edge2 state", 32'(seq_state), 32'd1);
    steps(8);  chk("edge10 stages", 32'(rst_n_stage), 32'b0001);
    chk("edge10 state", 32'(seq_state), 32'd2);
    steps(4);  chk("edge14 stages", 32'(rst_n_stage), 32'b0011);
    steps(4);  chk("edge18 stages", 32'(rst_n_stage), 32'b0111);
    steps(4);  chk("edge22 stages", 32'(rst_n_stage), 32'b1111);
    chk("edge22 done", 32'(seq_done), 32'd1);
    chk("edge22 state", 32'(seq_state), 32'd3);

    // Software reset from RUN.
    steps(2);
    sw_rst_req = 1'b1; steps(1); sw_rst_req = 1'b0;
    chk("sw stages", 32'(rst_n_stage), 32'd0);
    chk("sw state", 32'(seq_state), 32'd1);
    chk("sw lost", 32'(lock_lost_cnt), 32'd0);
    steps(7);  chk("sw +7 stage0", 32'(rst_n_stage[0]), 32'd0);
    steps(1);  chk("sw +8 stage0", 32'(rst_n_stage[0]), 32'd1);
    steps(12); chk("sw rerun state", 32'(seq_state), 32'd3);

    // Lock loss in RUN.
    locked_in = 1'b0;
    steps(2);  chk("loss +2 state", 32'(seq_state), 32'd3);
    steps(1);
    chk("loss stages", 32'(rst_n_stage), 32'd0);
    chk("loss done", 32'(seq_done), 32'd0);
    chk("loss lost", 32'(lock_lost_cnt), 32'd1);
    chk("loss state", 32'(seq_state), 32'd0);

    // sw request and lock loss together during RELEASE.
    locked_in = 1'b1;
    steps(12); chk("relock release", 32'(seq_state), 32'd2);
    locked_in = 1'b0;
    steps(2);
    sw_rst_req = 1'b1; steps(1); sw_rst_req = 1'b0;
    chk("both state", 32'(seq_state), 32'd0);
    chk("both lost", 32'(lock_lost_cnt), 32'd2);

    // Short drop during STABLE restarts the full wait without counting a loss.
    locked_in = 1'b1;
    steps(8);  chk("stable cnt5 state", 32'(seq_state), 32'd1);
    locked_in = 1'b0;
    steps(3);
    chk("drop state", 32'(seq_state), 32'd0);
    chk("drop lost", 32'(lock_lost_cnt), 32'd2);
    locked_in = 1'b1;
    steps(10); chk("rewait still stable", 32'(seq_state), 32'd1);
    steps(1);  chk("rewait release", 32'(seq_state), 32'd2);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      sys_rst    = ($urandom_range(599) == 0);
      sw_rst_req = ($urandom_range(24) == 0);
      if ($urandom_range(49) == 0) locked_in = ~locked_in;
      steps(1);
    end
    sys_rst = 1'b0; sw_rst_req = 1'b0;

    // Force enough losses to saturate the counter.
    for (int i = 0; i < 300; i++) begin
      locked_in = 1'b1; steps(12);
      locked_in = 1'b0; steps(4);
    end
    chk("saturated lost", 32'(lock_lost_cnt), 32'd255);

    sys_rst = 1'b1; steps(1);
    chk("final reset state", 32'(seq_state), 32'd0);
    chk("final reset stages", 32'(rst_n_stage), 32'd0);
    chk("final reset done", 32'(seq_done), 32'd0);
    chk("final reset lost", 32'(lock_lost_cnt), 32'd0);
    sys_rst = 1'b0; steps(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
